// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared state encoding and helpers for the UART TX arbiter
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_GAP     = 2'd2
  } arb_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART TX handshake bundle for the arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_busy;
  logic                 new_data_tx;
  logic [7:0]           data_tx;
  logic                 timeout_err;

  // master: requesters plus the UART core's busy flag; slave: the arbiter
  modport master (
    output req, req_valid, req_last, req_data, tx_busy,
    input  req_ack, grant, new_data_tx, data_tx, timeout_err
  );

  modport slave (
    input  req, req_valid, req_last, req_data, tx_busy,
    output req_ack, grant, new_data_tx, data_tx, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin pick starting after rr_ptr
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PW = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               any_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Offsets 1..NUM_REQ so the previous owner is checked last
  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (!any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin sharing of one UART transmitter
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int PW = clog2(NUM_REQ);
  localparam int WW = clog2(TIMEOUT);
  localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);
  localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT - 1);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [PW-1:0]      owner_q;
  logic [PW-1:0]      rr_ptr_q;
  logic [WW-1:0]      wdog_q;
  logic               last_q;
  logic               strobe_q;
  logic               terr_q;
  logic [7:0]         data_q;

  logic [NUM_REQ-1:0] grant_d;
  logic [PW-1:0]      owner_d;
  logic               pick_any;
  logic [7:0]         owner_byte;

  uart_tx_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (grant_d),
    .any_o    (pick_any)
  );

  always_comb begin
    owner_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_d[i]) owner_d = PW'(i);
    end
  end

  assign owner_byte = bus.req_data[{owner_q, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ack_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= LAST_REQ;
      wdog_q   <= '0;
      last_q   <= 1'b0;
      strobe_q <= 1'b0;
      terr_q   <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      strobe_q <= 1'b0;
      ack_q    <= '0;
      terr_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q <= grant_d;
            owner_q <= owner_d;
            wdog_q  <= '0;
            state_q <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          // A dropped request wins over a byte that happens to be valid
          if (!bus.req[owner_q]) begin
            grant_q  <= '0;
            rr_ptr_q <= owner_q;
            state_q  <= ST_IDLE;
          end else if (bus.req_valid[owner_q] && !bus.tx_busy) begin
            strobe_q <= 1'b1;
            data_q   <= owner_byte;
            ack_q    <= grant_q;
            last_q   <= bus.req_last[owner_q];
            wdog_q   <= '0;
            state_q  <= ST_GAP;
          end else if (wdog_q == WDOG_MAX) begin
            grant_q  <= '0;
            rr_ptr_q <= owner_q;
            terr_q   <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            wdog_q <= wdog_q + WW'(1);
          end
        end
        ST_GAP: begin
          if (last_q) begin
            grant_q  <= '0;
            rr_ptr_q <= owner_q;
            state_q  <= ST_IDLE;
          end else begin
            state_q <= ST_GRANTED;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.req_ack     = ack_q;
  assign bus.new_data_tx = strobe_q;
  assign bus.data_tx     = data_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for the UART TX arbiter
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors;
  int miscompares;
  int cycle;

  logic [8:0]         pkt_q [NUM_REQ][$];
  logic [10:0]        exp_q [$];
  logic [NUM_REQ-1:0] grant_log [$];
  int                 gap_log [$];
  bit                 auto_drop [NUM_REQ];
  bit                 drop_after_ack [NUM_REQ];
  int                 acks_per [NUM_REQ];
  int                 strobes, terr_cnt, busy_len, busy_cnt, zero_run;
  int                 last_strobe_cycle, grant_rise_cycle, grant_fall_cycle, terr_cycle;
  logic [NUM_REQ-1:0] prev_grant;

  task automatic clear_tb();
    for (int i = 0; i < NUM_REQ; i++) begin
      pkt_q[i].delete();
      auto_drop[i]      = 1'b1;
      drop_after_ack[i] = 1'b0;
      acks_per[i]       = 0;
    end
    exp_q.delete();
    grant_log.delete();
    gap_log.delete();
    strobes = 0; terr_cnt = 0; busy_cnt = 0; zero_run = 0;
    last_strobe_cycle = 0; grant_rise_cycle = 0; grant_fall_cycle = 0; terr_cycle = 0;
    prev_grant    = '0;
    bus.req       = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.tx_busy   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_tb();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load(input int id, input logic [7:0] b, input logic last);
    pkt_q[id].push_back({last, b});
  endtask

  task automatic expect_byte(input int id, input logic [7:0] b);
    exp_q.push_back({3'(id), b});
  endtask

  task automatic drive_reqs();
    logic [8:0] head;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pkt_q[i].size() > 0) begin
        head = pkt_q[i][0];
        bus.req_valid[i]        = 1'b1;
        bus.req_last[i]         = head[8];
        bus.req_data[i*8 +: 8]  = head[7:0];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_last[i]  = 1'b0;
        if (auto_drop[i]) bus.req[i] = 1'b0;
      end
    end
  endtask

  // One clock: sample DUT outputs 1 time unit after the edge, then react as requesters and UART
  task automatic step();
    logic               busy_prev;
    logic [10:0]        e;
    logic [NUM_REQ-1:0] exp_ack;
    busy_prev = bus.tx_busy;
    @(posedge clk);
    #1;
    cycle++;
    if (bus.new_data_tx === 1'b1) begin
      strobes++;
      last_strobe_cycle = cycle;
      vectors++;
      if (busy_prev !== 1'b0) begin
        miscompares++;
        $display("FAIL strobe_while_busy: new_data_tx=1 although tx_busy=%b at the edge, required no strobe", busy_prev);
      end
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: data_tx=%h req_ack=%b, required no strobe", bus.data_tx, bus.req_ack);
      end else begin
        e = exp_q.pop_front();
        exp_ack = NUM_REQ'(1) << e[10:8];
        if (bus.data_tx !== e[7:0] || bus.req_ack !== exp_ack) begin
          miscompares++;
          $display("FAIL sb_byte: data_tx=%h req_ack=%b, required data_tx=%h req_ack=%b",
                   bus.data_tx, bus.req_ack, e[7:0], exp_ack);
        end
      end
      busy_cnt = busy_len;
    end
    if (bus.timeout_err === 1'b1) begin
      terr_cnt++;
      terr_cycle = cycle;
    end
    if (bus.grant !== '0 && prev_grant === '0) begin
      grant_log.push_back(bus.grant);
      if (grant_log.size() > 1) gap_log.push_back(zero_run);
      grant_rise_cycle = cycle;
    end
    if (bus.grant === '0 && prev_grant !== '0) grant_fall_cycle = cycle;
    zero_run   = (bus.grant === '0) ? zero_run + 1 : 0;
    prev_grant = bus.grant;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_ack[i] === 1'b1) begin
        acks_per[i]++;
        if (pkt_q[i].size() > 0) void'(pkt_q[i].pop_front());
        if (drop_after_ack[i]) begin
          pkt_q[i].delete();
          bus.req[i] = 1'b0;
        end
      end
    end
    bus.tx_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    drive_reqs();
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.grant !== '0 || bus.req !== '0) && n < max_cycles) begin
      step();
      n++;
    end
    vectors++;
    if (n >= max_cycles) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d bytes outstanding after %0d cycles, required 0", name, exp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_tb();
    @(posedge clk);
    #1;
    vectors++;
    if (bus.grant !== '0) begin miscompares++; $display("FAIL reset_grant: got %b, required 0000", bus.grant); end
    vectors++;
    if (bus.req_ack !== '0) begin miscompares++; $display("FAIL reset_ack: got %b, required 0000", bus.req_ack); end
    vectors++;
    if (bus.new_data_tx !== 1'b0) begin miscompares++; $display("FAIL reset_strobe: got %b, required 0", bus.new_data_tx); end
    vectors++;
    if (bus.data_tx !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h, required 00", bus.data_tx); end
    vectors++;
    if (bus.timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_terr: got %b, required 0", bus.timeout_err); end
    rst = 1'b0;
    step();
    vectors++;
    if (bus.grant !== '0) begin miscompares++; $display("FAIL idle_no_req_grant: got %b, required 0000", bus.grant); end
  endtask

  task automatic test_single_packet();
    do_reset();
    busy_len = 10;
    load(0, 8'h41, 1'b0); load(0, 8'h42, 1'b0); load(0, 8'h43, 1'b1);
    expect_byte(0, 8'h41); expect_byte(0, 8'h42); expect_byte(0, 8'h43);
    bus.req[0] = 1'b1;
    drive_reqs();
    wait_done("single", 300);
    vectors++;
    if (strobes != 3) begin miscompares++; $display("FAIL single_strobes: got %0d, required 3", strobes); end
    vectors++;
    if (acks_per[0] != 3) begin miscompares++; $display("FAIL single_acks: got %0d, required 3", acks_per[0]); end
    vectors++;
    if (grant_log.size() != 1 || grant_log[0] !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_grant: %0d grants, first %b, required one grant 0001", grant_log.size(), prev_grant);
    end
    // Last byte sampled one cycle before its strobe; grant falls two cycles after that sample
    vectors++;
    if (grant_fall_cycle - last_strobe_cycle != 1) begin
      miscompares++;
      $display("FAIL single_release: grant fell %0d cycles after strobe, required 1", grant_fall_cycle - last_strobe_cycle);
    end
  endtask

  task automatic test_two_requesters();
    logic [NUM_REQ-1:0] exp_g [3] = '{4'b0010, 4'b0100, 4'b0010};
    logic [NUM_REQ-1:0] got;
    do_reset();
    busy_len = 2;
    load(1, 8'hA1, 1'b1); load(1, 8'hB1, 1'b1);
    load(2, 8'hC2, 1'b1);
    expect_byte(1, 8'hA1); expect_byte(2, 8'hC2); expect_byte(1, 8'hB1);
    bus.req[1] = 1'b1;
    bus.req[2] = 1'b1;
    drive_reqs();
    wait_done("two_req", 300);
    vectors++;
    if (grant_log.size() != 3) begin miscompares++; $display("FAIL two_req_count: got %0d grants, required 3", grant_log.size()); end
    for (int j = 0; j < 3; j++) begin
      got = (j < grant_log.size()) ? grant_log[j] : 'x;
      vectors++;
      if (got !== exp_g[j]) begin miscompares++; $display("FAIL two_req_order[%0d]: got %b, required %b", j, got, exp_g[j]); end
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [NUM_REQ-1:0] got;
    do_reset();
    busy_len = 0;
    load(0, 8'h50, 1'b1); load(0, 8'h51, 1'b1);
    load(1, 8'h60, 1'b1); load(2, 8'h70, 1'b1); load(3, 8'h80, 1'b1);
    expect_byte(0, 8'h50); expect_byte(1, 8'h60); expect_byte(2, 8'h70);
    expect_byte(3, 8'h80); expect_byte(0, 8'h51);
    bus.req = '1;
    drive_reqs();
    wait_done("rr", 300);
    for (int j = 0; j < 5; j++) begin
      got = (j < grant_log.size()) ? grant_log[j] : 'x;
      vectors++;
      if (got !== exp_g[j]) begin miscompares++; $display("FAIL rr_order[%0d]: got %b, required %b", j, got, exp_g[j]); end
    end
    vectors++;
    if (gap_log.size() != 4) begin miscompares++; $display("FAIL rr_gap_count: got %0d gaps, required 4", gap_log.size()); end
    foreach (gap_log[j]) begin
      vectors++;
      if (gap_log[j] != 1) begin miscompares++; $display("FAIL rr_gap[%0d]: got %0d idle cycles, required 1", j, gap_log[j]); end
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    busy_len = 0;
    auto_drop[3] = 1'b0;
    bus.req[3] = 1'b1;
    n = 0;
    while (bus.grant === '0 && n < 10) begin step(); n++; end
    n = 0;
    while (bus.grant !== '0 && n < 4 * TIMEOUT) begin step(); n++; end
    bus.req[3] = 1'b0;
    repeat (4) step();
    vectors++;
    if (grant_log.size() != 1 || grant_log[0] !== 4'b1000) begin
      miscompares++;
      $display("FAIL wdog_grant: got %0d grants, required one grant 1000", grant_log.size());
    end
    vectors++;
    if (grant_fall_cycle - grant_rise_cycle != TIMEOUT) begin
      miscompares++;
      $display("FAIL wdog_release: held %0d cycles, required %0d", grant_fall_cycle - grant_rise_cycle, TIMEOUT);
    end
    vectors++;
    if (terr_cnt != 1) begin miscompares++; $display("FAIL wdog_pulses: got %0d, required 1", terr_cnt); end
    vectors++;
    if (terr_cycle != grant_fall_cycle) begin
      miscompares++;
      $display("FAIL wdog_pulse_cycle: got cycle %0d, required %0d", terr_cycle, grant_fall_cycle);
    end
    vectors++;
    if (strobes != 0) begin miscompares++; $display("FAIL wdog_strobes: got %0d, required 0", strobes); end
  endtask

  task automatic test_drop_mid_packet();
    logic [NUM_REQ-1:0] exp_g [2] = '{4'b0001, 4'b0010};
    logic [NUM_REQ-1:0] got;
    do_reset();
    busy_len = 0;
    load(0, 8'h10, 1'b0); load(0, 8'h11, 1'b0); load(0, 8'h12, 1'b1);
    load(1, 8'h20, 1'b1);
    expect_byte(0, 8'h10); expect_byte(1, 8'h20);
    drop_after_ack[0] = 1'b1;
    bus.req[0] = 1'b1;
    bus.req[1] = 1'b1;
    drive_reqs();
    wait_done("drop", 200);
    vectors++;
    if (acks_per[0] != 1) begin miscompares++; $display("FAIL drop_acks0: got %0d, required 1", acks_per[0]); end
    vectors++;
    if (acks_per[1] != 1) begin miscompares++; $display("FAIL drop_acks1: got %0d, required 1", acks_per[1]); end
    for (int j = 0; j < 2; j++) begin
      got = (j < grant_log.size()) ? grant_log[j] : 'x;
      vectors++;
      if (got !== exp_g[j]) begin miscompares++; $display("FAIL drop_order[%0d]: got %b, required %b", j, got, exp_g[j]); end
    end
  endtask

  task automatic test_reset_in_gap();
    int n;
    do_reset();
    busy_len = 0;
    // Move rr_ptr off its reset value so the post-reset winner proves it was restored
    load(1, 8'h30, 1'b1);
    expect_byte(1, 8'h30);
    bus.req[1] = 1'b1;
    drive_reqs();
    wait_done("gap_pre", 100);
    load(2, 8'h40, 1'b0); load(2, 8'h41, 1'b1);
    expect_byte(2, 8'h40);
    bus.req[2] = 1'b1;
    drive_reqs();
    n = 0;
    while (!(bus.new_data_tx === 1'b1 && bus.grant[2] === 1'b1) && n < 20) begin step(); n++; end
    vectors++;
    if (n >= 20) begin miscompares++; $display("FAIL gap_reach: no strobe from requester 2 in %0d cycles, required one", n); end
    bus.tx_busy = 1'b1;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.grant !== '0) begin miscompares++; $display("FAIL gap_rst_grant: got %b, required 0000", bus.grant); end
    vectors++;
    if (bus.new_data_tx !== 1'b0) begin miscompares++; $display("FAIL gap_rst_strobe: got %b, required 0", bus.new_data_tx); end
    vectors++;
    if (bus.data_tx !== 8'h00) begin miscompares++; $display("FAIL gap_rst_data: got %h, required 00", bus.data_tx); end
    vectors++;
    if (bus.req_ack !== '0) begin miscompares++; $display("FAIL gap_rst_ack: got %b, required 0000", bus.req_ack); end
    clear_tb();
    @(posedge clk);
    #1;
    rst = 1'b0;
    busy_len = 0;
    load(0, 8'h50, 1'b1); load(2, 8'h60, 1'b1);
    expect_byte(0, 8'h50); expect_byte(2, 8'h60);
    bus.req[0] = 1'b1;
    bus.req[2] = 1'b1;
    drive_reqs();
    wait_done("gap_post", 100);
    vectors++;
    if (grant_log.size() == 0 || grant_log[0] !== 4'b0001) begin
      miscompares++;
      $display("FAIL gap_post_first: first grant %b, required 0001", (grant_log.size() > 0) ? grant_log[0] : 4'bxxxx);
    end
    vectors++;
    if (strobes != 2) begin miscompares++; $display("FAIL gap_post_strobes: got %0d, required 2", strobes); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycle       = 0;
    busy_len    = 0;
    rst         = 1'b1;
    test_reset();
    test_single_packet();
    test_two_requesters();
    test_round_robin();
    test_timeout();
    test_drop_mid_packet();
    test_reset_in_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
